opcode_fetch_buffer: RTL and testbench

- Stage-1 front end of the pipelined 8-bit RISC. Sits directly upstream of the stage-2 control code generator and feeds it.
- Prefetches program bytes from synchronous program memory into a small byte FIFO.
- Assembles each instruction as an opcode plus an optional operand byte <od>, and presents one instruction per cycle to stage 2.
- Honours the stage-2 hold (BB2) and the PC-load redirect (LPC).

---
 rtl/opcode_fetch_buffer.sv | 129 ++++++++++++
 tb/tb_opcode_fetch_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/opcode_fetch_buffer.sv
// opcode_fetch_buffer: stage-1 front end of the 8-bit RISC pipeline.
// It prefetches program bytes into a small byte FIFO. From the FIFO it assembles
// opcode(+operand) instructions and issues one per cycle to stage 2.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   hold                   stage-2 hold (BB2): freeze issue outputs, no pop
//   redirect, redirect_pc  PC load (LPC): flush buffer, restart fetch
//   mem_rd, mem_addr       program-memory read strobe / address (combinational)
//   mem_data               read data, valid one cycle after a mem_rd edge
//   opcode, od, ins_valid, ins_pc   registered issue outputs
//   fifo_level             bytes currently buffered
module opcode_fetch_buffer #(
  parameter int unsigned   AW       = 8,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold,
  input  logic                       redirect,
  input  logic [AW-1:0]              redirect_pc,
  output logic                       mem_rd,
  output logic [AW-1:0]              mem_addr,
  input  logic [7:0]                 mem_data,
  output logic [7:0]                 opcode,
  output logic [7:0]                 od,
  output logic                       ins_valid,
  output logic [AW-1:0]              ins_pc,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] head_pc;
  logic          inflight;
  logic [7:0]    fifo [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;

  logic [7:0]    head_byte;
  logic [7:0]    next_byte;
  logic          head_two;
  logic          complete;
  logic          pop;
  logic          push;
  logic [LW-1:0] pop_cnt;

  // Opcodes that carry a trailing operand byte.
  function automatic logic needs_od(input logic [7:0] op);
    logic r;
    r = 1'b0;
    if (op == 8'h03 || op == 8'h05) r = 1'b1;
    if (op[7:3] == 5'b00001 || op[7:3] == 5'b00110 || op[7:3] == 5'b01011) r = 1'b1;
    if (op[7] && op[3] && (op[7:4] != 4'hF)) r = 1'b1;
    return r;
  endfunction

  // Head decode, pop/push decisions and the read strobe.
  always_comb begin
    head_byte = fifo[rd_ptr];
    next_byte = fifo[rd_ptr + PW'(1)];
    head_two  = needs_od(head_byte);
    complete  = (level >= LW'(2)) || ((level == LW'(1)) && !head_two);
    pop       = !redirect && !hold && complete;
    pop_cnt   = '0;
    if (pop) pop_cnt = head_two ? LW'(2) : LW'(1);
    push      = inflight && !redirect;
    // A single outstanding read is counted against free space so returns never overflow.
    mem_rd    = rst_n && !redirect && ((level + LW'(inflight)) < LW'(DEPTH));
  end

  assign mem_addr   = fetch_pc;
  assign fifo_level = level;

  // Byte storage; contents need no reset because level/pointers gate them.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_data;
  end

  // Fetch, FIFO bookkeeping and issue registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      head_pc   <= RESET_PC;
      inflight  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      opcode    <= 8'h00;
      od        <= 8'h00;
      ins_valid <= 1'b0;
      ins_pc    <= '0;
    end else if (redirect) begin
      // Flush wins over hold; the return of any outstanding read is dropped.
      fetch_pc  <= redirect_pc;
      head_pc   <= redirect_pc;
      inflight  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      opcode    <= 8'h00;
      od        <= 8'h00;
      ins_valid <= 1'b0;
    end else begin
      if (mem_rd) fetch_pc <= fetch_pc + AW'(1);
      inflight <= mem_rd;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr  <= rd_ptr + PW'(pop_cnt);
      level   <= level + LW'(push) - pop_cnt;
      head_pc <= head_pc + AW'(pop_cnt);
      if (!hold) begin
        if (pop) begin
          opcode    <= head_byte;
          od        <= head_two ? next_byte : 8'h00;
          ins_valid <= 1'b1;
          ins_pc    <= head_pc;
        end else begin
          opcode    <= 8'h00;
          od        <= 8'h00;
          ins_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_opcode_fetch_buffer.sv
// Directed testbench for opcode_fetch_buffer with a synchronous program-memory model.
module tb_opcode_fetch_buffer;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] opcode;
  logic [7:0] od;
  logic       ins_valid;
  logic [7:0] ins_pc;
  logic [2:0] fifo_level;

  logic [7:0] mem [256];
  int vectors;
  int miscompares;

  opcode_fetch_buffer #(.AW(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .opcode(opcode), .od(od), .ins_valid(ins_valid),
    .ins_pc(ins_pc), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory: data appears one cycle after the read edge.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Asynchronous reset pulse; released just after an edge so the next edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    hold = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if (opcode !== 8'h00) begin miscompares++; $display("FAIL reset.opcode got %h want 00", opcode); end
    vectors++; if (od !== 8'h00) begin miscompares++; $display("FAIL reset.od got %h want 00", od); end
    vectors++; if (ins_valid !== 1'b0) begin miscompares++; $display("FAIL reset.ins_valid got %b want 0", ins_valid); end
    vectors++; if (ins_pc !== 8'h00) begin miscompares++; $display("FAIL reset.ins_pc got %h want 00", ins_pc); end
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL reset.mem_rd got %b want 0", mem_rd); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL reset.fifo_level got %0d want 0", fifo_level); end
    vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL reset.mem_addr got %h want 00", mem_addr); end
  endtask

  task automatic test_basic();
    logic       e_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] e_op [6] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h8A, 8'h00};
    logic [7:0] e_od [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00};
    logic [7:0] e_pc [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
    logic [2:0] e_lv [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd1};
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h8A; mem[2] = 8'h3C; mem[3] = 8'h00;
    do_reset();
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      vectors++; if (ins_valid !== e_v[e]) begin miscompares++; $display("FAIL basic.ins_valid edge %0d got %b want %b", e+1, ins_valid, e_v[e]); end
      vectors++; if (opcode !== e_op[e]) begin miscompares++; $display("FAIL basic.opcode edge %0d got %h want %h", e+1, opcode, e_op[e]); end
      vectors++; if (od !== e_od[e]) begin miscompares++; $display("FAIL basic.od edge %0d got %h want %h", e+1, od, e_od[e]); end
      vectors++; if (ins_pc !== e_pc[e]) begin miscompares++; $display("FAIL basic.ins_pc edge %0d got %h want %h", e+1, ins_pc, e_pc[e]); end
      vectors++; if (fifo_level !== e_lv[e]) begin miscompares++; $display("FAIL basic.fifo_level edge %0d got %0d want %0d", e+1, fifo_level, e_lv[e]); end
      vectors++; if (mem_addr !== 8'(e + 1)) begin miscompares++; $display("FAIL basic.mem_addr edge %0d got %h want %h", e+1, mem_addr, 8'(e + 1)); end
    end
  endtask

  task automatic test_hold();
    logic [2:0] h_lv [5] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic       h_rd [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h8A; mem[2] = 8'h3C;
    for (int i = 3; i < 12; i++) mem[i] = 8'(8'h0D + i);
    do_reset();
    for (int e = 0; e < 5; e++) begin @(posedge clk); #1; end
    vectors++; if (opcode !== 8'h8A || od !== 8'h3C) begin miscompares++; $display("FAIL hold.pre got %h/%h want 8a/3c", opcode, od); end
    hold = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      vectors++; if (opcode !== 8'h8A || od !== 8'h3C || ins_valid !== 1'b1 || ins_pc !== 8'h01) begin
        miscompares++; $display("FAIL hold.frozen cycle %0d got %h/%h/%b/%h want 8a/3c/1/01", e, opcode, od, ins_valid, ins_pc); end
      vectors++; if (fifo_level !== h_lv[e]) begin miscompares++; $display("FAIL hold.fifo_level cycle %0d got %0d want %0d", e, fifo_level, h_lv[e]); end
      vectors++; if (mem_rd !== h_rd[e]) begin miscompares++; $display("FAIL hold.mem_rd cycle %0d got %b want %b", e, mem_rd, h_rd[e]); end
    end
    hold = 1'b0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      vectors++; if (opcode !== 8'(8'h10 + e) || ins_valid !== 1'b1 || od !== 8'h00) begin
        miscompares++; $display("FAIL hold.resume.opcode step %0d got %h/%b want %h/1", e, opcode, ins_valid, 8'(8'h10 + e)); end
      vectors++; if (ins_pc !== 8'(3 + e)) begin miscompares++; $display("FAIL hold.resume.ins_pc step %0d got %h want %h", e, ins_pc, 8'(3 + e)); end
    end
    // Reset in the middle of a running stream clears everything immediately.
    rst_n = 1'b0; #1;
    vectors++; if (fifo_level !== 3'd0 || ins_valid !== 1'b0 || opcode !== 8'h00 || mem_rd !== 1'b0 || mem_addr !== 8'h00 || ins_pc !== 8'h00) begin
      miscompares++; $display("FAIL midreset got lvl %0d v %b op %h rd %b addr %h pc %h want 0/0/00/0/00/00", fifo_level, ins_valid, opcode, mem_rd, mem_addr, ins_pc); end
  endtask

  task automatic test_operand_wait();
    logic       e_v  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] e_op [5] = '{8'h8A, 8'h10, 8'h00, 8'h0B, 8'h10};
    logic [7:0] e_od [5] = '{8'h3C, 8'h00, 8'h00, 8'h77, 8'h00};
    logic [7:0] e_pc [5] = '{8'h00, 8'h02, 8'h02, 8'h03, 8'h05};
    logic [2:0] e_lv [5] = '{3'd2, 3'd1, 3'd2, 3'd1, 3'd1};
    clear_mem();
    mem[0] = 8'h8A; mem[1] = 8'h3C; mem[2] = 8'h10; mem[3] = 8'h0B;
    mem[4] = 8'h77; mem[5] = 8'h10; mem[6] = 8'h11;
    do_reset();
    hold = 1'b1;
    for (int e = 0; e < 5; e++) begin @(posedge clk); #1; end
    vectors++; if (fifo_level !== 3'd4 || mem_rd !== 1'b0 || ins_valid !== 1'b0) begin
      miscompares++; $display("FAIL opwait.full got lvl %0d rd %b v %b want 4/0/0", fifo_level, mem_rd, ins_valid); end
    hold = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      vectors++; if (ins_valid !== e_v[e] || opcode !== e_op[e] || od !== e_od[e]) begin
        miscompares++; $display("FAIL opwait.issue step %0d got %b/%h/%h want %b/%h/%h", e, ins_valid, opcode, od, e_v[e], e_op[e], e_od[e]); end
      vectors++; if (ins_pc !== e_pc[e]) begin miscompares++; $display("FAIL opwait.ins_pc step %0d got %h want %h", e, ins_pc, e_pc[e]); end
      vectors++; if (fifo_level !== e_lv[e]) begin miscompares++; $display("FAIL opwait.fifo_level step %0d got %0d want %0d", e, fifo_level, e_lv[e]); end
    end
  endtask

  task automatic test_redirect();
    logic       e_v  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] e_op [4] = '{8'h00, 8'h00, 8'h20, 8'h21};
    logic [7:0] e_pc [4] = '{8'h00, 8'h00, 8'h40, 8'h41};
    logic [2:0] e_lv [4] = '{3'd0, 3'd1, 3'd1, 3'd1};
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h8A; mem[2] = 8'h3C; mem[3] = 8'h10;
    mem[8'h40] = 8'h20; mem[8'h41] = 8'h21; mem[8'h42] = 8'h22; mem[8'h43] = 8'h23;
    do_reset();
    hold = 1'b1;
    for (int e = 0; e < 4; e++) begin @(posedge clk); #1; end
    vectors++; if (fifo_level !== 3'd3 || mem_addr !== 8'h04) begin
      miscompares++; $display("FAIL redir.pre got lvl %0d addr %h want 3/04", fifo_level, mem_addr); end
    hold = 1'b0; redirect = 1'b1; redirect_pc = 8'h40; #1;
    vectors++; if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL redir.mem_rd got %b want 0", mem_rd); end
    @(posedge clk); #1;
    vectors++; if (ins_valid !== 1'b0 || opcode !== 8'h00 || od !== 8'h00) begin
      miscompares++; $display("FAIL redir.bubble got %b/%h/%h want 0/00/00", ins_valid, opcode, od); end
    vectors++; if (fifo_level !== 3'd0 || mem_addr !== 8'h40) begin
      miscompares++; $display("FAIL redir.flush got lvl %0d addr %h want 0/40", fifo_level, mem_addr); end
    redirect = 1'b0; #1;
    vectors++; if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL redir.resume_rd got %b want 1", mem_rd); end
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      vectors++; if (fifo_level !== e_lv[e]) begin miscompares++; $display("FAIL redir.fifo_level step %0d got %0d want %0d", e, fifo_level, e_lv[e]); end
      vectors++; if (ins_valid !== e_v[e] || opcode !== e_op[e]) begin
        miscompares++; $display("FAIL redir.issue step %0d got %b/%h want %b/%h", e, ins_valid, opcode, e_v[e], e_op[e]); end
      if (e_v[e]) begin
        vectors++; if (ins_pc !== e_pc[e]) begin miscompares++; $display("FAIL redir.ins_pc step %0d got %h want %h", e, ins_pc, e_pc[e]); end
      end
    end
  endtask

  // Runs on from test_redirect's state; redirect to FE exercises the address wrap.
  task automatic test_redirect_hold_wrap();
    logic       e_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] e_op [6] = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h8A, 8'h21};
    logic [7:0] e_od [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00};
    logic [7:0] e_pc [6] = '{8'h00, 8'h00, 8'hFE, 8'h00, 8'hFF, 8'h01};
    logic [2:0] e_lv [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd1};
    logic [7:0] e_ad [6] = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    mem[8'hFE] = 8'h20; mem[8'hFF] = 8'h8A; mem[0] = 8'h5A; mem[1] = 8'h21;
    vectors++; if (ins_valid !== 1'b1) begin miscompares++; $display("FAIL rh.pre got %b want 1", ins_valid); end
    hold = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
    @(posedge clk); #1;
    vectors++; if (ins_valid !== 1'b0 || opcode !== 8'h00 || od !== 8'h00) begin
      miscompares++; $display("FAIL rh.bubble got %b/%h/%h want 0/00/00", ins_valid, opcode, od); end
    vectors++; if (fifo_level !== 3'd0 || mem_addr !== 8'hFE) begin
      miscompares++; $display("FAIL rh.flush got lvl %0d addr %h want 0/fe", fifo_level, mem_addr); end
    hold = 1'b0; redirect = 1'b0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      vectors++; if (ins_valid !== e_v[e] || opcode !== e_op[e] || od !== e_od[e]) begin
        miscompares++; $display("FAIL wrap.issue step %0d got %b/%h/%h want %b/%h/%h", e, ins_valid, opcode, od, e_v[e], e_op[e], e_od[e]); end
      vectors++; if (fifo_level !== e_lv[e] || mem_addr !== e_ad[e]) begin
        miscompares++; $display("FAIL wrap.fetch step %0d got lvl %0d addr %h want %0d/%h", e, fifo_level, mem_addr, e_lv[e], e_ad[e]); end
      if (e_v[e]) begin
        vectors++; if (ins_pc !== e_pc[e]) begin miscompares++; $display("FAIL wrap.ins_pc step %0d got %h want %h", e, ins_pc, e_pc[e]); end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    hold = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    mem_data = 8'h00;
    clear_mem();
    test_reset();
    test_basic();
    test_hold();
    test_operand_wait();
    test_redirect();
    test_redirect_hold_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
